// File: rtl/data_bus_pkg.sv
// Shared constants, state encoding and helpers for the data bus initiator.
// Misalignment trapping is built only when DATA_BUS_MISALIGN_TRAP_EN is defined.
package data_bus_pkg;

    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == SIZE_BYTE)
            return 1'b0;
        else if (size == SIZE_HALF)
            return addr_lo[0];
        else
            return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/data_bus_lane.sv
// Byte-lane steering: load extract/extend from a bus word and sub-word merge into a bus word.
module data_bus_lane
    import data_bus_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_sh = {addr_lo_i, 3'b000};
    assign half_sh = {addr_lo_i[1], 4'b0000};

    always_comb begin
        byte_v       = 8'(rd_word_i >> byte_sh);
        half_v       = 16'(rd_word_i >> half_sh);
        load_data_o  = rd_word_i;
        store_word_o = wdata_i;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o  = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                store_word_o = (rd_word_i & ~(32'h0000_00FF << byte_sh))
                             | ({24'h0, wdata_i[7:0]} << byte_sh);
            end
            SIZE_HALF: begin
                load_data_o  = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                store_word_o = (rd_word_i & ~(32'h0000_FFFF << half_sh))
                             | ({16'h0, wdata_i[15:0]} << half_sh);
            end
            default: begin
                load_data_o  = rd_word_i;
                store_word_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_master.sv
// Initiator for the shared 32-bit data bus; sub-word stores use read-modify-write.
// Define DATA_BUS_MISALIGN_TRAP_EN to answer misaligned requests with rsp_error instead of a bus cycle.
module data_bus_master
    import data_bus_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    inout  wire  [31:0] data_bus_data,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode
);

    state_e      state_q, state_d;
    logic [29:0] waddr_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_buf_q;
    logic        accept;
    logic        misaligned;
    logic        err_q;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept = (state_q == IDLE) && req_valid;

`ifdef DATA_BUS_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (accept)
            err_q <= misaligned;
    end

    assign rsp_error = (state_q == DONE) && err_q;
`else
    assign misaligned = 1'b0;
    assign err_q      = 1'b0;
    assign rsp_error  = 1'b0;
`endif

    data_bus_lane u_lane (
        .addr_lo_i    (lo_q),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .rd_word_i    (rd_buf_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            lo_q       <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rd_buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                waddr_q    <= req_addr[31:2];
                lo_q       <= req_addr[1:0];
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
            end
            if (state_q == RD)
                rd_buf_q <= data_bus_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        data_bus_mode = BUS_IDLE;
        data_bus_addr = IDLE_ADDR;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned)
                        state_d = DONE;
                    else if (!req_write || is_subword(req_size))
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD: begin
                data_bus_mode = BUS_READ;
                data_bus_addr = {waddr_q, 2'b00};
                // A store only reaches RD when it is sub-word and needs the merge.
                state_d       = write_q ? WR : DONE;
            end
            WR: begin
                data_bus_mode = BUS_WRITE;
                data_bus_addr = {waddr_q, 2'b00};
                state_d       = DONE;
            end
            default: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    assign rsp_rdata     = (state_q == DONE && !write_q && !err_q) ? load_data : '0;
    assign data_bus_data = (state_q == WR) ? store_word : 'z;

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master against an LED register peripheral at 0x4F00.
// Expected values follow DATA_BUS_MISALIGN_TRAP_EN when it is defined.
module tb_data_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    wire  [31:0] bus_data;
    logic [31:0] bus_addr;
    logic [1:0]  bus_mode;

    logic [31:0] leds = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_bus_master #(.IDLE_ADDR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .data_bus_data (bus_data),
        .data_bus_addr (bus_addr),
        .data_bus_mode (bus_mode)
    );

    // LED peripheral: answers reads and takes writes at word address 0x4F00.
    assign bus_data = (bus_mode == 2'b01 && bus_addr == 32'h0000_4F00) ? leds : 'z;
    always @(posedge clk)
        if (bus_mode == 2'b10 && bus_addr == 32'h0000_4F00)
            leds <= bus_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; reports latency in sampled cycles after the accept edge and the bus activity seen.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int n_rd, output int n_wr,
                          output logic [31:0] wr_data, output logic [31:0] cyc_addr);
        logic got;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        lat = 0; rdata = '0; err = 1'b0; n_rd = 0; n_wr = 0; wr_data = '0; cyc_addr = '0;
        got = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (bus_mode == 2'b01) begin n_rd++; cyc_addr = bus_addr; end
            if (bus_mode == 2'b10) begin n_wr++; cyc_addr = bus_addr; wr_data = bus_data; end
            if (rsp_valid) begin
                got = 1'b1; lat = i; rdata = rsp_rdata; err = rsp_error;
            end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat, n_rd, n_wr, n_acc, rsp_cnt, wr_seen;
        int          acc_cyc[3];
        logic [31:0] rdata, wr_data, cyc_addr;
        logic        err;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_error", 32'(rsp_error), 32'd0);
        check("rst_mode", 32'(bus_mode), 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        reset = 1'b1;

        // Word store
        do_req(1'b1, 2'b10, 1'b0, 32'h4F00, 32'h0000_00A5, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("ws_lat", 32'(lat), 32'd2);
        check("ws_nrd", 32'(n_rd), 32'd0);
        check("ws_nwr", 32'(n_wr), 32'd1);
        check("ws_addr", cyc_addr, 32'h4F00);
        check("ws_data", wr_data, 32'h0000_00A5);
        check("ws_rdata", rdata, 32'h0);
        check("ws_leds", leds, 32'h0000_00A5);

        do_req(1'b1, 2'b10, 1'b0, 32'h4F00, 32'h0000_80F0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("ws2_leds", leds, 32'h0000_80F0);

        // Loads with extension
        do_req(1'b0, 2'b00, 1'b0, 32'h4F00, 32'h0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("lbs_lat", 32'(lat), 32'd2);
        check("lbs_nrd", 32'(n_rd), 32'd1);
        check("lbs_addr", cyc_addr, 32'h4F00);
        check("lbs_data", rdata, 32'hFFFF_FFF0);
        do_req(1'b0, 2'b00, 1'b1, 32'h4F01, 32'h0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("lbu_addr", cyc_addr, 32'h4F00);
        check("lbu_data", rdata, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b0, 32'h4F00, 32'h0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("lhs_data", rdata, 32'hFFFF_80F0);

        // Byte store read-modify-write
        do_req(1'b1, 2'b10, 1'b0, 32'h4F00, 32'h1122_3344, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        do_req(1'b1, 2'b00, 1'b0, 32'h4F02, 32'h0000_0012, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_nrd", 32'(n_rd), 32'd1);
        check("sb_nwr", 32'(n_wr), 32'd1);
        check("sb_addr", cyc_addr, 32'h4F00);
        check("sb_data", wr_data, 32'h1112_3344);
        check("sb_leds", leds, 32'h1112_3344);
        check("sb_rdata", rdata, 32'h0);

        do_req(1'b0, 2'b00, 1'b1, 32'h4F03, 32'h0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("lbu3_data", rdata, 32'h0000_0011);

        // Half store to upper lane, then signed half load back
        do_req(1'b1, 2'b01, 1'b0, 32'h4F02, 32'h0000_BEEF, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_data", wr_data, 32'hBEEF_3344);
        do_req(1'b0, 2'b01, 1'b0, 32'h4F02, 32'h0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
        check("lhs2_data", rdata, 32'hFFFF_BEEF);

        // Misaligned word load
        do_req(1'b0, 2'b10, 1'b0, 32'h4F02, 32'h0, lat, rdata, err, n_rd, n_wr, wr_data, cyc_addr);
`ifdef DATA_BUS_MISALIGN_TRAP_EN
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(err), 32'd1);
        check("mis_rdata", rdata, 32'h0);
        check("mis_nbus", 32'(n_rd + n_wr), 32'd0);
`else
        check("mis_lat", 32'(lat), 32'd2);
        check("mis_err", 32'(err), 32'd0);
        check("mis_addr", cyc_addr, 32'h4F00);
        check("mis_rdata", rdata, 32'hBEEF_3344);
`endif

        // Reset during the write cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h4F00; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_rd", 32'(bus_mode), 32'd1);
        @(negedge clk);
        check("rst_mid_wr", 32'(bus_mode), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_mode", 32'(bus_mode), 32'd0);
        check("rst_mid_addr", bus_addr, 32'h0);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_leds", leds, 32'hBEEF_3344);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check("rst_mid_norsp", 32'(rsp_cnt), 32'd0);

        // Back-to-back loads with req_valid held high
        n_acc = 0; rsp_cnt = 0; wr_seen = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4F00;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (n_acc == 3) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                acc_cyc[n_acc] = i;
                n_acc++;
            end
            if (bus_mode == 2'b10) wr_seen++;
            if (rsp_valid) begin
                rsp_cnt++;
                check("b2b_rdata", rsp_rdata, 32'hBEEF_3344);
            end
        end
        check("b2b_nacc", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        check("b2b_nrsp", 32'(rsp_cnt), 32'd3);
        check("b2b_nowr", 32'(wr_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
